modn_step_counter: RTL
======================

Name: modn_step_counter

Overview:
Parametrised successor to the lab's fixed six-state Moore stepper. Holds a modulo-MOD state register that advances on an internally divided tick. Each tick steps up by UP_STEP or down by DN_STEP, selected by a direction input. Adds synchronous load, enable/pause, a wrap pulse and a sticky load-error flag, and drives an active-low seven-segment digit of the current state. Sits between the board clock/switches and one HEX display.

Parameters:
MOD, 6, state modulus; legal range 2..16; state counts 0..MOD-1
DIV, 25000000, clock cycles per step tick; legal range 1..2^32-1
UP_STEP, 1, increment applied when dir=1; legal range 0..MOD-1
DN_STEP, 2, decrement applied when dir=0; legal range 0..MOD-1

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
en  in  1  1 = divider runs and steps occur; 0 = pause (divider and state hold)
dir  in  1  1 = step up by UP_STEP; 0 = step down by DN_STEP
load  in  1  synchronous load strobe
load_val  in  4  value loaded into state when load=1
state  out  4  current state, zero-extended, always < MOD
tick  out  1  combinational step strobe = en & (div_cnt == DIV-1)
wrap  out  1  registered; 1-cycle pulse after a step that crossed the modulus
err  out  1  sticky; set by an illegal load, cleared only by reset
seg  out  7  active-low segments {g,f,e,d,c,b,a} decoding state as hex

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset values: div_cnt=0, state=0, wrap=0, err=0. Consequently tick=0 and seg=7'b1000000.
- Divider (32-bit div_cnt):
  - With en=1: div_cnt counts 0..DIV-1, then returns to 0.
  - With en=0: div_cnt holds.
  - With DIV=1, tick equals en every cycle.
- Step, on the rising edge where tick=1 and load=0:
  - dir=1: state <= (state+UP_STEP) mod MOD; wrap <= (state+UP_STEP >= MOD).
  - dir=0: state <= (state+MOD-DN_STEP) mod MOD; wrap <= (state < DN_STEP).
  - Arithmetic is done at 5 bits, so no overflow for MOD<=16.
- wrap is 0 on every edge that does not perform a step.
- Load (load=1) has priority over tick on the same edge:
  - load_val < MOD: state <= load_val, div_cnt <= 0, wrap <= 0.
  - load_val >= MOD: state and div_cnt are unchanged, err <= 1, wrap <= 0.
  - Load is honoured regardless of en.
- dir is sampled only on the stepping edge; changing dir between ticks has no effect until the next tick.
- Reset mid-count clears everything immediately. The first tick after release occurs DIV edges after reset deasserts, provided en=1.
- seg is combinational from state. Hex glyphs, active-low, in order 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- MOD outside 2..16 is a configuration error; the implementation guards it with a simulation-time $error.

Optional Feature:
TICK_BYPASS_EN
- Defined: the divider is not built and tick = en every cycle (for fast simulation and unit test). A load with a legal value still updates state; there is no divider to clear.
- Undefined: the full DIV divider is used as described above.

Test Plan:
- MOD=6, DIV=4, en=1, dir=1 from reset: tick pulses every 4th cycle; state goes 1,2,3,4,5,0; wrap pulses one cycle after the 5->0 step only.
- MOD=6, DN_STEP=2, dir=0, load 1 and then run: state goes 5 (wrap=1), 3, 1, 5 (wrap=1); seg shows 0010010 for state 5.
- Load and tick on the same edge with load_val=2 from state 4: state=2, div_cnt=0, wrap=0; the next tick arrives 4 cycles later.
- Load load_val=7 with MOD=6: state unchanged, err=1 and stays 1 through later legal loads, until reset.
- en=0 for 10 cycles mid-count at div_cnt=2: state and div_cnt frozen, tick=0; after re-enable, the tick arrives 1 cycle later.
- Assert reset asynchronously mid-cycle at state=3, err=1: state=0, err=0, wrap=0, seg=1000000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/modn_step_counter_if.sv
// Bundle between the board switches and one modn_step_counter: control strobes in,
// counter state, status flags and the seven-segment digit out.
interface modn_step_counter_if;
    // No valid/ready pair here: en, dir and load are level/strobe inputs sampled on every
    // rising clock edge. A load is consumed on the edge where load=1 and cannot be refused.
    // The outputs state, wrap, err and seg are always valid; tick is a combinational strobe.
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] state;
    logic       tick;
    logic       wrap;
    logic       err;
    logic [6:0] seg;

    modport master (
        output en, dir, load, load_val,
        input  state, tick, wrap, err, seg
    );

    modport slave (
        input  en, dir, load, load_val,
        output state, tick, wrap, err, seg
    );
endinterface

// File: rtl/modn_step_counter.sv
// Modulo-MOD up/down stepper advanced by a DIV-cycle tick, with load, error flag and hex digit.
// Define TICK_BYPASS_EN to drop the divider so that tick follows en every cycle.
module modn_step_counter #(
    parameter int          MOD     = 6,
    parameter int unsigned DIV     = 25000000,
    parameter int          UP_STEP = 1,
    parameter int          DN_STEP = 2
) (
    input logic               clock,
    input logic               reset,
    modn_step_counter_if.slave bus
);

    localparam logic [4:0] MOD5 = 5'(MOD);
    localparam logic [4:0] UP5  = 5'(UP_STEP);
    localparam logic [4:0] DN5  = 5'(DN_STEP);

    if (MOD < 2 || MOD > 16) begin : g_bad_mod
        $error("modn_step_counter: MOD=%0d outside 2..16", MOD);
    end

    logic [3:0] state_q, state_d;
    logic       wrap_q, wrap_d;
    logic       err_q, err_d;
    logic       tick;
    logic       load_ok;
    logic [4:0] up_sum, dn_sum, nxt5;

    assign load_ok = bus.load && ({1'b0, bus.load_val} < MOD5);

`ifdef TICK_BYPASS_EN
    assign tick = bus.en;
`else
    localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

    logic [31:0] div_cnt_q, div_cnt_d;

    assign tick = bus.en && (div_cnt_q == DIV_LAST);

    // An illegal load leaves the divider untouched, even while enabled.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (bus.load) begin
            if (load_ok) div_cnt_d = '0;
        end else if (bus.en) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end
`endif

    // Sums are 5 bits wide so state+MOD never overflows for MOD up to 16.
    always_comb begin
        up_sum  = {1'b0, state_q} + UP5;
        dn_sum  = {1'b0, state_q} + MOD5 - DN5;
        nxt5    = {1'b0, state_q};
        state_d = state_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (bus.load) begin
            if (load_ok) state_d = bus.load_val;
            else         err_d   = 1'b1;
        end else if (tick) begin
            if (bus.dir) begin
                wrap_d = (up_sum >= MOD5);
                nxt5   = (up_sum >= MOD5) ? up_sum - MOD5 : up_sum;
            end else begin
                wrap_d = ({1'b0, state_q} < DN5);
                nxt5   = (dn_sum >= MOD5) ? dn_sum - MOD5 : dn_sum;
            end
            state_d = nxt5[3:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        case (state_q)
            4'h0:    bus.seg = 7'b1000000;
            4'h1:    bus.seg = 7'b1111001;
            4'h2:    bus.seg = 7'b0100100;
            4'h3:    bus.seg = 7'b0110000;
            4'h4:    bus.seg = 7'b0011001;
            4'h5:    bus.seg = 7'b0010010;
            4'h6:    bus.seg = 7'b0000010;
            4'h7:    bus.seg = 7'b1111000;
            4'h8:    bus.seg = 7'b0000000;
            4'h9:    bus.seg = 7'b0010000;
            4'hA:    bus.seg = 7'b0001000;
            4'hB:    bus.seg = 7'b0000011;
            4'hC:    bus.seg = 7'b1000110;
            4'hD:    bus.seg = 7'b0100001;
            4'hE:    bus.seg = 7'b0000110;
            default: bus.seg = 7'b0001110;
        endcase
    end

    assign bus.state = state_q;
    assign bus.tick  = tick;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

endmodule
